dlfloat_round_pack: RTL and testbench

- Back end of the DLFloat16 arithmetic result path.
- Consumes the 20-bit extended result {sign, exp[5:0], frac[12:0]} and its 5-bit exception flags from an arithmetic unit such as the divider.
- Rounds and packs the result into a 16-bit DLFloat16 word {sign, exp[5:0], frac[8:0]}, bias 31, no denormals.
- 2-stage valid/ready pipeline with full throughput under backpressure, plus a saturating inexact-result counter.

---
 rtl/dlfloat_pkg.sv | 21 ++
 rtl/dlfloat_rnd_core.sv | 69 ++++++
 rtl/dlfloat_round_pack.sv | 83 ++++++++
 tb/tb_dlfloat_round_pack.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, special encodings, flag positions
// and rounding-mode encodings used by the round/pack datapath.
package dlfloat_pkg;

    localparam int DLF_BIAS = 31;
    localparam logic [14:0] DLF_INF = 15'h7FFF;

    localparam int EXP_W    = 6;
    localparam int FRAC16_W = 9;
    localparam int FRAC20_W = 13;

    localparam int FLG_INV = 4;
    localparam int FLG_INX = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_DBZ = 0;

    localparam int RND_RNE = 0;
    localparam int RND_RTZ = 1;

endpackage

// File: rtl/dlfloat_rnd_core.sv
// Combinational round/pack of one 20-bit extended result into a DLFloat16 word,
// merging the newly raised inexact/overflow flags into the incoming flags.
module dlfloat_rnd_core
    import dlfloat_pkg::*;
#(
    parameter int RND_MODE = RND_RNE
) (
    input  logic [19:0] ext_res,
    input  logic [4:0]  ext_flags,
    output logic [15:0] pack_res,
    output logic [4:0]  pack_flags
);

    logic                sign;
    logic [EXP_W-1:0]    exp_val;
    logic [FRAC20_W-1:0] frac;
    logic [FRAC16_W-1:0] keep;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [FRAC16_W:0]   frac_sum;
    logic [EXP_W:0]      exp_adj;
    logic [FRAC16_W-1:0] frac_adj;
    logic                is_inf;
    logic                is_zero;
    logic                inexact;
    logic                ovf;
    logic [4:0]          new_flags;

    assign sign    = ext_res[19];
    assign exp_val = ext_res[18:13];
    assign frac    = ext_res[12:0];
    assign keep    = frac[12:4];
    assign guard   = frac[3];
    assign sticky  = |frac[2:0];

    assign round_up = (RND_MODE == RND_RNE) ? (guard && (sticky || keep[0])) : 1'b0;
    assign inexact  = guard || sticky;

    // A carry out of the kept fraction renormalises to 1.0 at the next exponent.
    assign frac_sum = {1'b0, keep} + {{FRAC16_W{1'b0}}, round_up};
    assign exp_adj  = {1'b0, exp_val} + {{EXP_W{1'b0}}, frac_sum[FRAC16_W]};
    assign frac_adj = frac_sum[FRAC16_W] ? '0 : frac_sum[FRAC16_W-1:0];

    // Landing exactly on the all-ones pattern would alias the inf encoding.
    assign ovf = exp_adj[EXP_W] ||
                 ((exp_adj[EXP_W-1:0] == 6'h3F) && (frac_adj == 9'h1FF));

    assign is_inf  = (ext_res[18:4] == DLF_INF);
    assign is_zero = (ext_res[18:0] == 19'd0);

    always_comb begin
        new_flags          = '0;
        new_flags[FLG_INX] = inexact;
        new_flags[FLG_OVF] = ovf;
        pack_res           = {sign, exp_adj[EXP_W-1:0], frac_adj};
        pack_flags         = ext_flags | new_flags;
        if (is_inf) begin
            pack_res   = {sign, DLF_INF};
            pack_flags = ext_flags;
        end else if (is_zero) begin
            pack_res   = {sign, 15'h0000};
            pack_flags = ext_flags;
        end else if (ovf) begin
            pack_res   = {sign, DLF_INF};
        end
    end

endmodule

// File: rtl/dlfloat_round_pack.sv
// Two-stage valid/ready round-and-pack back end for DLFloat16 results, with a
// saturating count of inexact results leaving the block.
module dlfloat_round_pack
    import dlfloat_pkg::*;
#(
    parameter int RND_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [19:0]      in_res,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_res,
    output logic [4:0]       out_flags,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] inexact_cnt
);

    logic        s1_valid;
    logic [15:0] s1_res;
    logic [4:0]  s1_flags;
    logic [15:0] rnd_res;
    logic [4:0]  rnd_flags;
    logic        adv2;
    logic        out_xfer;

    dlfloat_rnd_core #(
        .RND_MODE(RND_MODE)
    ) u_rnd_core (
        .ext_res   (in_res),
        .ext_flags (in_flags),
        .pack_res  (rnd_res),
        .pack_flags(rnd_flags)
    );

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign out_xfer = out_valid && out_ready;

    // Stage 1 refills whenever it is empty or its content moves to stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_flags <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_res   <= rnd_res;
                s1_flags <= rnd_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_flags <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res   <= s1_res;
                out_flags <= s1_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inexact_cnt <= '0;
        end else if (cnt_clr) begin
            inexact_cnt <= '0;
        end else if (out_xfer && out_flags[FLG_INX] && (inexact_cnt != '1)) begin
            inexact_cnt <= inexact_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dlfloat_round_pack.sv
// Table-driven bench for dlfloat_round_pack: RNE, RTZ and 2-bit-counter
// instances share stimulus; a queue scoreboard checks results in order.
module tb_dlfloat_round_pack;

    typedef struct packed {
        logic [19:0] res;
        logic [4:0]  flags;
        logic [15:0] rne;
        logic [4:0]  rne_flg;
        logic [15:0] rtz;
        logic [4:0]  rtz_flg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_res;
    logic [4:0]  in_flags;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, rtz_in_ready, sat_in_ready;
    logic        out_valid, rtz_out_valid, sat_out_valid;
    logic [15:0] out_res, rtz_out_res, sat_out_res;
    logic [4:0]  out_flags, rtz_out_flags, sat_out_flags;
    logic [15:0] inexact_cnt, rtz_cnt;
    logic [1:0]  sat_cnt;

    vec_t vecs[14];
    vec_t sb[$];
    vec_t mon_exp;
    int   n_checks;
    int   n_pass;
    int   model_cnt;
    int   model_sat;

    dlfloat_round_pack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_flags(in_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
        .cnt_clr(cnt_clr), .inexact_cnt(inexact_cnt)
    );

    dlfloat_round_pack #(.RND_MODE(1)) dut_rtz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rtz_in_ready),
        .in_res(in_res), .in_flags(in_flags), .out_valid(rtz_out_valid),
        .out_ready(out_ready), .out_res(rtz_out_res), .out_flags(rtz_out_flags),
        .cnt_clr(cnt_clr), .inexact_cnt(rtz_cnt)
    );

    dlfloat_round_pack #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_res(in_res), .in_flags(in_flags), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_res(sat_out_res), .out_flags(sat_out_flags),
        .cnt_clr(cnt_clr), .inexact_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bit done = 0;
        int waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_res   = v.res;
        in_flags = v.flags;
        while (!done && waits < 50) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(v);
                done = 1;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        if (!done) begin
            check_output("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_output("drain_timeout", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Scoreboard consumer and counter model; a transfer seen here completes at the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_out", 32'(out_res), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = sb.pop_front();
                    check_output("out_res", 32'(out_res), 32'(mon_exp.rne));
                    check_output("out_flags", 32'(out_flags), 32'(mon_exp.rne_flg));
                    check_output("rtz_valid", 32'(rtz_out_valid), 32'd1);
                    check_output("rtz_res", 32'(rtz_out_res), 32'(mon_exp.rtz));
                    check_output("rtz_flags", 32'(rtz_out_flags), 32'(mon_exp.rtz_flg));
                    check_output("sat_res", 32'(sat_out_res), 32'(mon_exp.rne));
                    check_output("sat_flags", 32'(sat_out_flags), 32'(mon_exp.rne_flg));
                    if (!cnt_clr && mon_exp.rne_flg[3]) begin
                        if (model_cnt < 65535) model_cnt++;
                        if (model_sat < 3) model_sat++;
                    end
                end
            end
            if (cnt_clr) begin
                model_cnt = 0;
                model_sat = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 0; rst_n = 0; in_valid = 0; in_res = '0; in_flags = '0;
        out_ready = 1; cnt_clr = 0;
        n_checks = 0; n_pass = 0; model_cnt = 0; model_sat = 0;

        vecs[0]  = '{20'h3E000, 5'h00, 16'h3E00, 5'h00, 16'h3E00, 5'h00};
        vecs[1]  = '{20'h3E008, 5'h00, 16'h3E00, 5'h08, 16'h3E00, 5'h08};
        vecs[2]  = '{20'h3E018, 5'h00, 16'h3E02, 5'h08, 16'h3E01, 5'h08};
        vecs[3]  = '{20'h3FFF8, 5'h00, 16'h4000, 5'h08, 16'h3FFF, 5'h08};
        vecs[4]  = '{20'h7FFEC, 5'h00, 16'h7FFF, 5'h0C, 16'h7FFE, 5'h08};
        vecs[5]  = '{20'hFFFF0, 5'h10, 16'hFFFF, 5'h10, 16'hFFFF, 5'h10};
        vecs[6]  = '{20'h80000, 5'h00, 16'h8000, 5'h00, 16'h8000, 5'h00};
        vecs[7]  = '{20'h3E000, 5'h03, 16'h3E00, 5'h03, 16'h3E00, 5'h03};
        vecs[8]  = '{20'h3E001, 5'h00, 16'h3E00, 5'h08, 16'h3E00, 5'h08};
        vecs[9]  = '{20'hBE018, 5'h00, 16'hBE02, 5'h08, 16'hBE01, 5'h08};
        vecs[10] = '{20'h7FFE0, 5'h00, 16'h7FFE, 5'h00, 16'h7FFE, 5'h00};
        vecs[11] = '{20'h7DFF8, 5'h00, 16'h7E00, 5'h08, 16'h7DFF, 5'h08};
        vecs[12] = '{20'h7FFF7, 5'h10, 16'h7FFF, 5'h10, 16'h7FFF, 5'h10};
        vecs[13] = '{20'h00000, 5'h01, 16'h0000, 5'h01, 16'h0000, 5'h01};

        // Reset state
        @(negedge clk);
        rst_n = 1;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_res", 32'(out_res), 32'd0);
        check_output("rst_out_flags", 32'(out_flags), 32'd0);
        check_output("rst_cnt", 32'(inexact_cnt), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_rtz_in_ready", 32'(rtz_in_ready), 32'd1);
        check_output("rst_sat_in_ready", 32'(sat_in_ready), 32'd1);

        // Back-to-back table
        for (int i = 0; i < 14; i++) apply_stimulus(vecs[i]);
        @(negedge clk);
        in_valid = 0;
        wait_drain();
        check_output("cnt_after_table", 32'(inexact_cnt), 32'(model_cnt));
        check_output("rtz_cnt_after_table", 32'(rtz_cnt), 32'(model_cnt));
        check_output("sat_cnt_after_table", 32'(sat_cnt), 32'(model_sat));

        // Latency into an empty pipeline
        apply_stimulus(vecs[2]);
        @(negedge clk);
        in_valid = 0;
        #1;
        check_output("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check_output("lat_cycle2_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // Backpressure: two accepted, third blocked, output held
        @(negedge clk);
        out_ready = 0;
        apply_stimulus(vecs[0]);
        apply_stimulus(vecs[2]);
        @(negedge clk);
        in_valid = 1; in_res = vecs[4].res; in_flags = vecs[4].flags;
        #1;
        check_output("bp_in_ready", 32'(in_ready), 32'd0);
        check_output("bp_rtz_in_ready", 32'(rtz_in_ready), 32'd0);
        check_output("bp_sat_in_ready", 32'(sat_in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_output("bp_hold_valid", 32'(out_valid), 32'd1);
            check_output("bp_hold_res", 32'(out_res), 32'h3E00);
            check_output("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        #1;
        check_output("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(vecs[4]);
        @(negedge clk);
        in_valid = 0;
        #1;
        check_output("bp_stream_b", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        check_output("bp_stream_c", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        check_output("bp_stream_end", 32'(out_valid), 32'd0);
        wait_drain();

        // Counter: clear, count, clear coincident with a transfer, saturate
        @(negedge clk);
        cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0;
        repeat (4) apply_stimulus(vecs[1]);
        @(negedge clk);
        in_valid = 0;
        wait_drain();
        check_output("cnt_four", 32'(inexact_cnt), 32'd4);
        check_output("sat_cnt_four", 32'(sat_cnt), 32'd3);
        apply_stimulus(vecs[1]);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        #1;
        check_output("clr_coincide_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0;
        #1;
        check_output("cnt_clr_priority", 32'(inexact_cnt), 32'd0);
        check_output("sat_cnt_clr_priority", 32'(sat_cnt), 32'd0);
        repeat (5) apply_stimulus(vecs[1]);
        @(negedge clk);
        in_valid = 0;
        wait_drain();
        check_output("cnt_five", 32'(inexact_cnt), 32'd5);
        check_output("sat_cnt_saturated", 32'(sat_cnt), 32'd3);

        // Asynchronous reset with both stages full
        @(negedge clk);
        out_ready = 0;
        apply_stimulus(vecs[0]);
        apply_stimulus(vecs[2]);
        @(negedge clk);
        in_valid = 0;
        #1;
        check_output("prerst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check_output("arst_out_valid", 32'(out_valid), 32'd0);
        check_output("arst_out_res", 32'(out_res), 32'd0);
        check_output("arst_cnt", 32'(inexact_cnt), 32'd0);
        check_output("arst_sat_cnt", 32'(sat_cnt), 32'd0);
        check_output("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        model_cnt = 0;
        model_sat = 0;
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check_output("no_stale_after_reset", 32'(out_valid), 32'd0);
        end
        apply_stimulus(vecs[2]);
        @(negedge clk);
        in_valid = 0;
        wait_drain();
        check_output("cnt_after_reset", 32'(inexact_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
